fetch_prefetch_queue: RTL and testbench
=======================================

// Module: fetch_prefetch_queue
// PURPOSE
//   Parametrised instruction-fetch front end for the RV32I core. Generates sequential
//   PCs, issues pipelined read requests to instruction memory with variable latency,
//   buffers returned words in a DEPTH-entry queue, and delivers {pc, instr} to decode
//   over a valid/ready handshake. A redirect (branch/jump/reset vector) flushes the
//   queue and discards all in-flight responses. Sits between imem and decode.
// PARAMETERS
//   XLEN      32      address/PC width
//   DEPTH     4       queue entries; also the maximum number of outstanding requests (power of 2, >=2)
//   RESET_PC  32'h0   fetch PC after reset
// PORTS
//   clk             in   1       clock, rising edge
//   rst             in   1       asynchronous, active-low reset
//   redirect_valid  in   1       flush and restart fetch at redirect_pc
//   redirect_pc     in   XLEN    new fetch PC; bits [1:0] ignored (treated as 0)
//   imem_req_valid  out  1       request valid
//   imem_req_ready  in   1       memory accepts request this cycle
//   imem_req_addr   out  XLEN    word-aligned request address
//   imem_rsp_valid  in   1       response valid; responses return in request order
//   imem_rsp_data   in   32      instruction word
//   out_valid       out  1       head of queue valid
//   out_ready       in   1       decode accepts head
//   out_pc          out  XLEN    PC of head instruction
//   out_instr       out  32      head instruction word
//   occupancy       out  $clog2(DEPTH)+1  queued entries
// BEHAVIOUR
//   Reset (rst=0, async): fetch_pc=RESET_PC, occ=0, outstanding=0, drop=0;
//     imem_req_valid=0, out_valid=0, out_pc=0, out_instr=0, occupancy=0.
//   Issue: imem_req_valid = !redirect_valid && (occ + outstanding < DEPTH);
//     imem_req_addr = fetch_pc. Accept (valid&&ready): fetch_pc += 4 (wraps mod 2^XLEN),
//     outstanding += 1. Credit check uses registered counts (no same-cycle dequeue credit).
//   Response: if drop>0, word discarded and drop -= 1 (outstanding -= 1); else word
//     written to queue tail with its PC (tracked by a response-PC register that
//     advances by 4 per kept response), occ += 1, outstanding -= 1.
//   Latency: response registered into queue; out_valid rises the cycle after the first
//     kept rsp (zero-wait memory: req accept -> out_valid = 2 cycles). No bypass.
//   Output: out_valid = (occ != 0) && !redirect_valid; dequeue when out_valid && out_ready.
//     Simultaneous enqueue+dequeue: occ unchanged. Full queue never overflows (credit).
//   Redirect (one-cycle pulse or held): next cycle occ=0, head/tail pointers reset,
//     fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2],2'b00}; drop = outstanding after
//     counting this cycle's accepts/rsps (a rsp arriving in the redirect cycle is discarded).
//     No request issued and no dequeue in a redirect cycle. Redirect while drop>0 accumulates.
//   Reset mid-operation: all state cleared immediately; responses to pre-reset requests
//     are the memory's responsibility to suppress (imem shares rst).
//   Counter widths: occ, outstanding, drop are $clog2(DEPTH)+1 bits; none exceeds DEPTH.
// STRUCTURE
//   Package rv_fetch_pkg: XLEN default, ILEN=32, INSTR_BYTES=4, NOP=32'h0000_0013.
//   Sub-module sync_fifo #(WIDTH=XLEN+32, DEPTH) with push/pop/flush/count, async
//   active-low rst; top level holds PC generation, credit and drop counters.
// TESTING
//   1 Reset release, RESET_PC=0, zero-wait mem, out_ready=1 -> req addrs 0,4,8,..;
//     out_valid at cycle 2; out_pc 0,4,8 with matching instrs, one per cycle.
//   2 out_ready=0, mem always ready -> exactly DEPTH=4 requests issued, occupancy=4,
//     imem_req_valid stays 0 until a dequeue frees a slot.
//   3 Memory latency 3, 2 requests outstanding, redirect_pc=32'h100 -> both late rsps
//     discarded, next out_pc=0x100, no stale instr ever has out_valid=1.
//   4 redirect_pc=32'h103 -> imem_req_addr=0x100; redirect in same cycle as rsp and
//     dequeue -> rsp dropped, no handshake completes, occupancy=0 next cycle.
//   5 fetch_pc=32'hFFFF_FFFC -> next request addr 0x0000_0000 (wrap).
//   6 Assert rst low mid-stream with occ=3 -> outputs zero same cycle (async);
//     after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
//   Xlen       default address/PC width
//   Ilen       instruction word width
//   InstrBytes bytes per instruction (PC stride)
//   Nop        canonical RV32I nop (addi x0, x0, 0)
package fetch_prefetch_queue_pkg;

  localparam int unsigned Xlen       = 32;
  localparam int unsigned Ilen       = 32;
  localparam int unsigned InstrBytes = 4;
  localparam logic [31:0] Nop        = 32'h0000_0013;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Bus bundle between the fetch queue, instruction memory and decode.
//   redirect_valid/redirect_pc      flush request and new fetch PC
//   imem_req_valid/ready/addr       request channel to instruction memory
//   imem_rsp_valid/data             in-order response channel from memory
//   out_valid/ready/pc/instr        {pc, instr} delivery to decode
//   occupancy                       number of queued instructions
// master: the fetch queue; slave: the surrounding memory/decode environment.
interface fetch_prefetch_queue_if
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned Xlen  = 32,
  parameter int unsigned Depth = 4
);

  localparam int unsigned CntW = cnt_width(Depth);

  logic              redirect_valid;
  logic [Xlen-1:0]   redirect_pc;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [Xlen-1:0]   imem_req_addr;
  logic              imem_rsp_valid;
  logic [Ilen-1:0]   imem_rsp_data;
  logic              out_valid;
  logic              out_ready;
  logic [Xlen-1:0]   out_pc;
  logic [Ilen-1:0]   out_instr;
  logic [CntW-1:0]   occupancy;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, occupancy
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, occupancy
  );

endinterface

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with flush, used as the fetch instruction queue.
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   push_i, data_i  write data_i at the tail
//   pop_i           drop the head entry
//   flush_i         empty the FIFO; overrides push/pop in the same cycle
//   data_o          head entry (stale when empty)
//   count_o         number of stored entries, 0..Depth
// The caller guarantees no push when full and no pop when empty.
module sync_fifo
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        push_i,
  input  logic [Width-1:0]            data_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  output logic [Width-1:0]            data_o,
  output logic [cnt_width(Depth)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = cnt_width(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_i && !pop_i) begin
        count_q <= count_q + CntW'(1);
      end else if (pop_i && !push_i) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: sequential PC generation, pipelined imem requests
// limited by queue credit, in-order response queueing and {pc, instr} delivery.
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     fetch_prefetch_queue_if.master: redirect, imem req/rsp, decode output,
//           occupancy
// A redirect flushes the queue and marks every in-flight request to be dropped.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned    Xlen    = 32,
  parameter int unsigned    Depth   = 4,
  parameter logic [Xlen-1:0] ResetPc = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  fetch_prefetch_queue_if.master bus
);

  localparam int unsigned CntW  = cnt_width(Depth);
  localparam int unsigned FifoW = Xlen + Ilen;

  logic [Xlen-1:0]  fetch_pc_q, fetch_pc_d;
  logic [Xlen-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0]  outstanding_q, outstanding_d;
  logic [CntW-1:0]  drop_q, drop_d;
  logic [CntW-1:0]  occ;
  logic [CntW:0]    credit_used;
  logic [Xlen-1:0]  redirect_pc_aligned;
  logic [FifoW-1:0] head;
  logic             redirect, accept, rsp, keep, pop, out_valid;

  assign redirect            = bus.redirect_valid;
  assign redirect_pc_aligned = {bus.redirect_pc[Xlen-1:2], 2'b00};

  // Credit uses registered counts only; a same-cycle dequeue frees a slot next cycle.
  assign credit_used = {1'b0, occ} + {1'b0, outstanding_q};

  // rst_ni gates the request so it drops as soon as reset asserts.
  assign bus.imem_req_valid = rst_ni && !redirect && (credit_used < (CntW + 1)'(Depth));
  assign bus.imem_req_addr  = fetch_pc_q;
  assign accept             = bus.imem_req_valid && bus.imem_req_ready;

  // Responses in a redirect cycle or while stale requests drain are discarded.
  assign rsp  = bus.imem_rsp_valid;
  assign keep = rsp && (drop_q == '0) && !redirect;

  assign out_valid     = (occ != '0) && !redirect;
  assign pop           = out_valid && bus.out_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = (occ != '0) ? head[FifoW-1:Ilen] : '0;
  assign bus.out_instr = (occ != '0) ? head[Ilen-1:0] : '0;
  assign bus.occupancy = occ;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    if (accept) begin
      fetch_pc_d    = fetch_pc_q + Xlen'(InstrBytes);
      outstanding_d = outstanding_d + CntW'(1);
    end
    if (rsp) begin
      outstanding_d = outstanding_d - CntW'(1);
      if (drop_q != '0) drop_d = drop_q - CntW'(1);
    end
    if (keep) rsp_pc_d = rsp_pc_q + Xlen'(InstrBytes);

    // Everything still in flight after this cycle belongs to the old stream.
    if (redirect) begin
      fetch_pc_d = redirect_pc_aligned;
      rsp_pc_d   = redirect_pc_aligned;
      drop_d     = outstanding_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q    <= ResetPc;
      rsp_pc_q      <= ResetPc;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  sync_fifo #(
    .Width (FifoW),
    .Depth (Depth)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (keep),
    .data_i  ({rsp_pc_q, bus.imem_rsp_data}),
    .pop_i   (pop),
    .flush_i (redirect),
    .data_o  (head),
    .count_o (occ)
  );

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue. A behavioural memory returns
// in-order responses after a per-request latency; the reference model tags each
// request with a redirect epoch and keeps the expected decode stream in a queue.
module tb_fetch_prefetch_queue;

  localparam int unsigned Xlen  = 32;
  localparam int unsigned Depth = 4;
  localparam int unsigned OccW  = $clog2(Depth) + 1;
  localparam logic [31:0] ResetPc = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_prefetch_queue_if #(.Xlen(Xlen), .Depth(Depth)) bus ();

  fetch_prefetch_queue #(
    .Xlen    (Xlen),
    .Depth   (Depth),
    .ResetPc (ResetPc)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {logic [31:0] addr; int due; int epoch;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;

  pend_t       pend[$];
  ent_t        exp_q[$];
  logic [31:0] acc_addrs[$];
  logic [31:0] m_fetch_pc;
  int          m_epoch, last_due, cyc;
  int          lat_min, lat_max, rdy_pct;
  int          n_cmp, n_bad;
  int          n_acc, n_deq, acc_cyc0, deq_cyc0;
  logic [31:0] first_deq_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic cycle(input logic redir, input logic [31:0] rpc, input logic oready);
    pend_t h;
    ent_t  e;
    logic  rsp, exp_req, exp_out;
    int    due;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.out_ready      = oready;
    bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    rsp                = (pend.size() != 0) && (pend[0].due <= cyc);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? mem_word(pend[0].addr) : $urandom;
    #3;
    exp_req = !redir && (exp_q.size() + pend.size() < Depth);
    exp_out = !redir && (exp_q.size() != 0);
    n_cmp++;
    if (bus.imem_req_valid !== exp_req) begin
      n_bad++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, bus.imem_req_valid, exp_req);
    end
    if (bus.imem_req_valid === 1'b1) begin
      n_cmp++;
      if (bus.imem_req_addr !== m_fetch_pc) begin
        n_bad++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_req_addr, m_fetch_pc);
      end
    end
    n_cmp++;
    if (bus.out_valid !== exp_out) begin
      n_bad++;
      $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, exp_out);
    end
    n_cmp++;
    if (bus.occupancy !== OccW'(exp_q.size())) begin
      n_bad++;
      $display("FAIL occupancy cyc=%0d got=%0d exp=%0d", cyc, bus.occupancy, exp_q.size());
    end
    if (bus.out_valid === 1'b1 && oready) begin
      if (n_deq == 0) begin
        deq_cyc0     = cyc;
        first_deq_pc = bus.out_pc;
      end
      n_deq++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL deq_empty cyc=%0d got_pc=%h exp=no_entry", cyc, bus.out_pc);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
          n_bad++;
          $display("FAIL deq_data cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.out_pc,
                   bus.out_instr, e.pc, e.instr);
        end
      end
    end
    if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready) begin
      if (n_acc == 0) acc_cyc0 = cyc;
      n_acc++;
      acc_addrs.push_back(bus.imem_req_addr);
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: m_fetch_pc, due: due, epoch: m_epoch});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (rsp) begin
      h = pend.pop_front();
      if (h.epoch == m_epoch && !redir) exp_q.push_back('{pc: h.addr, instr: mem_word(h.addr)});
    end
    if (redir) begin
      exp_q.delete();
      m_epoch++;
      m_fetch_pc = {rpc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asserts reset mid-cycle, checks outputs clear at once, then releases it.
  task automatic do_reset();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_pc !== '0 ||
        bus.out_instr !== '0 || bus.occupancy !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b/%b/%h/%h/%0d exp=0/0/0/0/0", bus.imem_req_valid,
               bus.out_valid, bus.out_pc, bus.out_instr, bus.occupancy);
    end
    pend.delete();
    exp_q.delete();
    acc_addrs.delete();
    m_fetch_pc = ResetPc;
    last_due   = cyc;
    n_acc      = 0;
    n_deq      = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    do_reset();
    n_cmp++;
    if (bus.imem_req_addr !== ResetPc) begin
      n_bad++;
      $display("FAIL reset_pc got=%h exp=%h", bus.imem_req_addr, ResetPc);
    end
  endtask

  task automatic test_stream();
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1);
    n_cmp++;
    if (deq_cyc0 - acc_cyc0 != 2 || n_deq < 15) begin
      n_bad++;
      $display("FAIL stream_latency got=%0d deq=%0d exp=2 deq>=15", deq_cyc0 - acc_cyc0, n_deq);
    end
  endtask

  task automatic test_full();
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0);
    n_cmp++;
    if (n_acc != Depth || bus.occupancy !== OccW'(Depth) || bus.imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL full_credit got=%0d/%0d/%b exp=%0d/%0d/0", n_acc, bus.occupancy,
               bus.imem_req_valid, Depth, Depth);
    end
    cycle(1'b0, '0, 1'b1);
    n_cmp++;
    if (bus.imem_req_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL full_refill got=%b exp=1", bus.imem_req_valid);
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_redirect_late();
    int guard;
    lat_min = 3; lat_max = 3; rdy_pct = 100;
    do_reset();
    guard = 0;
    while (pend.size() < 2 && guard < 10) begin
      cycle(1'b0, '0, 1'b1);
      guard++;
    end
    n_cmp++;
    if (pend.size() != 2) begin
      n_bad++;
      $display("FAIL late_setup got=%0d exp=2", pend.size());
    end
    cycle(1'b1, 32'h100, 1'b1);
    n_deq = 0;
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1);
    n_cmp++;
    if (n_deq == 0 || first_deq_pc !== 32'h100) begin
      n_bad++;
      $display("FAIL late_first_pc got=%h n=%0d exp=00000100", first_deq_pc, n_deq);
    end
  endtask

  task automatic test_redirect_collision();
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
    n_cmp++;
    if (!(pend.size() != 0 && pend[0].due <= cyc && exp_q.size() != 0)) begin
      n_bad++;
      $display("FAIL collide_setup got=%0d/%0d exp=rsp_and_head", pend.size(), exp_q.size());
    end
    cycle(1'b1, 32'h103, 1'b1);
    n_cmp++;
    if (bus.occupancy !== '0) begin
      n_bad++;
      $display("FAIL collide_occ got=%0d exp=0", bus.occupancy);
    end
    acc_addrs.delete();
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
    n_cmp++;
    if (acc_addrs.size() == 0 || acc_addrs[0] !== 32'h100) begin
      n_bad++;
      $display("FAIL collide_addr got=%h exp=00000100",
               (acc_addrs.size() != 0) ? acc_addrs[0] : 32'hx);
    end
  endtask

  task automatic test_wrap();
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
    acc_addrs.delete();
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
    n_cmp++;
    if (acc_addrs.size() < 3 || acc_addrs[1] !== 32'hFFFF_FFFC || acc_addrs[2] !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_addr got=%0d entries exp=fffffff8,fffffffc,00000000",
               acc_addrs.size());
    end
  endtask

  task automatic test_random();
    logic redir;
    lat_min = 1; lat_max = 4; rdy_pct = 70;
    do_reset();
    redir = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      // Occasionally hold a redirect for several cycles.
      if (redir) redir = ($urandom_range(99) < 40);
      else       redir = ($urandom_range(99) < 3);
      cycle(redir, $urandom, ($urandom_range(99) < 65));
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int guard;
    lat_min = 1; lat_max = 1; rdy_pct = 100;
    do_reset();
    cycle(1'b1, 32'h0000_4000, 1'b0);
    guard = 0;
    while (exp_q.size() < 3 && guard < 20) begin
      cycle(1'b0, '0, 1'b0);
      guard++;
    end
    n_cmp++;
    if (bus.occupancy !== OccW'(3)) begin
      n_bad++;
      $display("FAIL midreset_setup got=%0d exp=3", bus.occupancy);
    end
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
    n_cmp++;
    if (acc_addrs.size() == 0 || acc_addrs[0] !== ResetPc || first_deq_pc !== ResetPc) begin
      n_bad++;
      $display("FAIL midreset_restart got=%h/%h exp=%h", 
               (acc_addrs.size() != 0) ? acc_addrs[0] : 32'hx, first_deq_pc, ResetPc);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; m_epoch = 0;
    first_deq_pc = '0; acc_cyc0 = 0; deq_cyc0 = 0;
    test_reset();
    test_stream();
    test_full();
    test_redirect_late();
    test_redirect_collision();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
